// File: rtl/level_generator.sv
// level_generator: emits a single level pulse lasting duration*TICK_DIV
// clk_in cycles. A local prescaler, cleared on every pulse start, produces the
// duration ticks. The pulse can be cut short by abort, and every pulse
// (including a zero-length one) ends with a one-cycle done strobe.
module level_generator #(
  parameter int              COUNT_BITS = 8,
  parameter longint unsigned TICK_DIV   = 64'd50000000  // legal range 2 .. 2^36-1
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic                  start,
  input  logic [COUNT_BITS-1:0] duration,
  input  logic                  abort,
  output logic                  lv_out,
  output logic                  busy,
  output logic                  done,
  output logic [COUNT_BITS-1:0] remaining
);

  // 36 bits holds TICK_DIV-1 for every legal TICK_DIV.
  localparam int                    PRESC_BITS = 36;
  localparam logic [PRESC_BITS-1:0] PRESC_LAST = PRESC_BITS'(TICK_DIV - 64'd1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [PRESC_BITS-1:0]   presc;
  logic [PRESC_BITS-1:0]   presc_next;
  logic [COUNT_BITS-1:0]   remaining_next;
  logic                    tick;
  logic                    last_tick;
  logic                    busy_next;
  logic                    done_next;

  // Prescaler only advances while a pulse is active, so tick is local to it.
  assign tick      = (state == ACTIVE) && (presc == PRESC_LAST);
  assign last_tick = tick && (remaining == COUNT_BITS'(1));

  // State register plus prescaler, remaining count and registered outputs.
  // NOTE: sequential state is written with <= so every register samples the
  // pre-edge values of its neighbours; = here would create ordering races.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      presc     <= '0;
      remaining <= '0;
      lv_out    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_next;
      presc     <= presc_next;
      remaining <= remaining_next;
      lv_out    <= busy_next;
      busy      <= busy_next;
      done      <= done_next;
    end
  end

  // Next-state logic; abort wins over both start and the final tick.
  // NOTE: every always_comb output gets a default on its first line so no
  // path through the case leaves it unassigned, which would infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_next = (duration == '0) ? DONE : ACTIVE;
        end
      end
      ACTIVE: begin
        if (abort || last_tick) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: prescaler clears on ACTIVE entry, remaining loads/decrements.
  always_comb begin
    presc_next     = '0;
    remaining_next = '0;
    case (state)
      IDLE: begin
        if (state_next == ACTIVE) begin
          remaining_next = duration;
        end
      end
      ACTIVE: begin
        if (state_next == ACTIVE) begin
          presc_next     = tick ? '0 : presc + PRESC_BITS'(1);
          remaining_next = (tick && (remaining != '0))
                           ? remaining - COUNT_BITS'(1)
                           : remaining;
        end
      end
      default: begin
        presc_next     = '0;
        remaining_next = '0;
      end
    endcase
  end

  // Output decode from the next state; the flops make the outputs registered.
  always_comb begin
    busy_next = (state_next == ACTIVE);
    done_next = (state_next == DONE);
  end

endmodule

// File: tb/tb_level_generator.sv
// Directed bench for level_generator with TICK_DIV=4, COUNT_BITS=8.
// Index i in each loop is the i-th cycle after the edge that accepted start.
module tb_level_generator;

  logic       clk_in;
  logic       reset;
  logic       start;
  logic [7:0] duration;
  logic       abort;
  logic       lv_out;
  logic       busy;
  logic       done;
  logic [7:0] remaining;

  int tests = 0;
  int fails = 0;

  level_generator #(
    .COUNT_BITS(8),
    .TICK_DIV  (64'd4)
  ) dut (
    .clk_in   (clk_in),
    .reset    (reset),
    .start    (start),
    .duration (duration),
    .abort    (abort),
    .lv_out   (lv_out),
    .busy     (busy),
    .done     (done),
    .remaining(remaining)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Advance one cycle; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    #2;
    tests++;
    if ({lv_out, busy, done, remaining} !== 11'd0) begin
      fails++;
      $display("FAIL reset_async got lv/busy/done/rem=%b/%b/%b/%0d exp 0/0/0/0", lv_out, busy, done, remaining);
    end
    step();
    tests++;
    if ({lv_out, busy, done, remaining} !== 11'd0) begin
      fails++;
      $display("FAIL reset_clocked got lv/busy/done/rem=%b/%b/%b/%0d exp 0/0/0/0", lv_out, busy, done, remaining);
    end
    // Release and request a 1-tick pulse on the very first edge.
    reset = 1'b0;
    start = 1'b1;
    duration = 8'd1;
    step();
    start = 1'b0;
    duration = 8'd0;
    for (int i = 0; i < 6; i++) begin
      logic       exp_lv;
      logic       exp_done;
      logic [7:0] exp_rem;
      exp_lv   = (i < 4);
      exp_rem  = (i < 4) ? 8'd1 : 8'd0;
      exp_done = (i == 4);
      tests++;
      if (lv_out !== exp_lv || busy !== exp_lv || remaining !== exp_rem || done !== exp_done) begin
        fails++;
        $display("FAIL first_start cyc=%0d got lv/busy/rem/done=%b/%b/%0d/%b exp %b/%b/%0d/%b",
                 i, lv_out, busy, remaining, done, exp_lv, exp_lv, exp_rem, exp_done);
      end
      step();
    end
  endtask

  task automatic test_basic();
    start = 1'b1;
    duration = 8'd3;
    step();
    start = 1'b0;
    duration = 8'd0;
    for (int i = 0; i < 16; i++) begin
      logic       exp_lv;
      logic       exp_done;
      logic [7:0] exp_rem;
      exp_lv   = (i < 12);
      exp_rem  = (i < 12) ? 8'(3 - i / 4) : 8'd0;
      exp_done = (i == 12);
      tests++;
      if (lv_out !== exp_lv || busy !== exp_lv || remaining !== exp_rem || done !== exp_done) begin
        fails++;
        $display("FAIL basic cyc=%0d got lv/busy/rem/done=%b/%b/%0d/%b exp %b/%b/%0d/%b",
                 i, lv_out, busy, remaining, done, exp_lv, exp_lv, exp_rem, exp_done);
      end
      step();
    end
  endtask

  task automatic test_zero_duration();
    start = 1'b1;
    duration = 8'd0;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic exp_done;
      exp_done = (i == 0);
      tests++;
      if (lv_out !== 1'b0 || busy !== 1'b0 || remaining !== 8'd0 || done !== exp_done) begin
        fails++;
        $display("FAIL zero_dur cyc=%0d got lv/busy/rem/done=%b/%b/%0d/%b exp 0/0/0/%b",
                 i, lv_out, busy, remaining, done, exp_done);
      end
      step();
    end
  endtask

  task automatic test_retrigger();
    start = 1'b1;
    duration = 8'd5;
    step();
    start = 1'b0;
    duration = 8'd0;
    for (int i = 0; i < 24; i++) begin
      logic       exp_lv;
      logic       exp_done;
      logic [7:0] exp_rem;
      exp_lv   = (i < 20);
      exp_rem  = (i < 20) ? 8'(5 - i / 4) : 8'd0;
      exp_done = (i == 20);
      tests++;
      if (lv_out !== exp_lv || busy !== exp_lv || remaining !== exp_rem || done !== exp_done) begin
        fails++;
        $display("FAIL retrigger cyc=%0d got lv/busy/rem/done=%b/%b/%0d/%b exp %b/%b/%0d/%b",
                 i, lv_out, busy, remaining, done, exp_lv, exp_lv, exp_rem, exp_done);
      end
      start    = (i == 7);
      duration = (i == 7) ? 8'd9 : 8'd0;
      step();
    end
    start = 1'b0;
  endtask

  task automatic test_abort();
    start = 1'b1;
    duration = 8'd10;
    step();
    start = 1'b0;
    duration = 8'd0;
    for (int i = 0; i < 12; i++) begin
      logic       exp_lv;
      logic       exp_done;
      logic [7:0] exp_rem;
      exp_lv   = (i <= 6);
      exp_rem  = (i <= 6) ? 8'(10 - i / 4) : 8'd0;
      exp_done = (i == 7);
      tests++;
      if (lv_out !== exp_lv || busy !== exp_lv || remaining !== exp_rem || done !== exp_done) begin
        fails++;
        $display("FAIL abort cyc=%0d got lv/busy/rem/done=%b/%b/%0d/%b exp %b/%b/%0d/%b",
                 i, lv_out, busy, remaining, done, exp_lv, exp_lv, exp_rem, exp_done);
      end
      abort = (i == 6);
      step();
    end
    abort = 1'b0;
    // Abort in IDLE does nothing and also blocks a simultaneous start.
    for (int i = 0; i < 5; i++) begin
      abort    = (i < 3);
      start    = (i == 1);
      duration = (i == 1) ? 8'd4 : 8'd0;
      step();
      tests++;
      if (lv_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || remaining !== 8'd0) begin
        fails++;
        $display("FAIL abort_idle cyc=%0d got lv/busy/rem/done=%b/%b/%0d/%b exp 0/0/0/0",
                 i, lv_out, busy, remaining, done);
      end
    end
    abort = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_abort_final_tick();
    start = 1'b1;
    duration = 8'd1;
    step();
    start = 1'b0;
    duration = 8'd0;
    for (int i = 0; i < 8; i++) begin
      logic       exp_lv;
      logic       exp_done;
      logic [7:0] exp_rem;
      exp_lv   = (i < 4);
      exp_rem  = (i < 4) ? 8'd1 : 8'd0;
      exp_done = (i == 4);
      tests++;
      if (lv_out !== exp_lv || busy !== exp_lv || remaining !== exp_rem || done !== exp_done) begin
        fails++;
        $display("FAIL abort_tick cyc=%0d got lv/busy/rem/done=%b/%b/%0d/%b exp %b/%b/%0d/%b",
                 i, lv_out, busy, remaining, done, exp_lv, exp_lv, exp_rem, exp_done);
      end
      abort = (i == 3);
      step();
    end
    abort = 1'b0;
  endtask

  task automatic test_reset_mid_pulse();
    start = 1'b1;
    duration = 8'd8;
    step();
    start = 1'b0;
    duration = 8'd0;
    for (int i = 0; i < 10; i++) step();
    tests++;
    if (lv_out !== 1'b1 || remaining !== 8'd6) begin
      fails++;
      $display("FAIL reset_mid_pre got lv/rem=%b/%0d exp 1/6", lv_out, remaining);
    end
    #3;
    reset = 1'b1;
    #1;
    tests++;
    if ({lv_out, busy, done, remaining} !== 11'd0) begin
      fails++;
      $display("FAIL reset_mid_async got lv/busy/done/rem=%b/%b/%b/%0d exp 0/0/0/0", lv_out, busy, done, remaining);
    end
    step();
    tests++;
    if ({lv_out, busy, done, remaining} !== 11'd0) begin
      fails++;
      $display("FAIL reset_mid_hold got lv/busy/done/rem=%b/%b/%b/%0d exp 0/0/0/0", lv_out, busy, done, remaining);
    end
    #2;
    reset = 1'b0;
    start = 1'b1;
    duration = 8'd2;
    step();
    start = 1'b0;
    duration = 8'd0;
    for (int i = 0; i < 12; i++) begin
      logic       exp_lv;
      logic       exp_done;
      logic [7:0] exp_rem;
      exp_lv   = (i < 8);
      exp_rem  = (i < 8) ? 8'(2 - i / 4) : 8'd0;
      exp_done = (i == 8);
      tests++;
      if (lv_out !== exp_lv || busy !== exp_lv || remaining !== exp_rem || done !== exp_done) begin
        fails++;
        $display("FAIL reset_mid_after cyc=%0d got lv/busy/rem/done=%b/%b/%0d/%b exp %b/%b/%0d/%b",
                 i, lv_out, busy, remaining, done, exp_lv, exp_lv, exp_rem, exp_done);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    start = 1'b1;
    duration = 8'd255;
    step();
    for (int i = 0; i < 1032; i++) begin
      logic       exp_lv;
      logic       exp_done;
      logic [7:0] exp_rem;
      if (i < 1020) begin
        exp_lv  = 1'b1;
        exp_rem = 8'(255 - i / 4);
      end else if (i >= 1022) begin
        exp_lv  = 1'b1;
        exp_rem = 8'(255 - (i - 1022) / 4);
      end else begin
        exp_lv  = 1'b0;
        exp_rem = 8'd0;
      end
      exp_done = (i == 1020);
      tests++;
      if (lv_out !== exp_lv || busy !== exp_lv || remaining !== exp_rem || done !== exp_done) begin
        fails++;
        $display("FAIL back_to_back cyc=%0d got lv/busy/rem/done=%b/%b/%0d/%b exp %b/%b/%0d/%b",
                 i, lv_out, busy, remaining, done, exp_lv, exp_lv, exp_rem, exp_done);
      end
      step();
    end
    start = 1'b0;
    duration = 8'd0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    tests++;
    if (lv_out !== 1'b0 || done !== 1'b1) begin
      fails++;
      $display("FAIL back_to_back_abort got lv/done=%b/%b exp 0/1", lv_out, done);
    end
    step();
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    duration = 8'd0;
    abort    = 1'b0;
    test_reset();
    test_basic();
    step();
    step();
    test_zero_duration();
    test_retrigger();
    test_abort();
    test_abort_final_tick();
    test_reset_mid_pulse();
    step();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard stop in case the run ever stalls.
  initial begin
    #500000;
    $display("FAIL watchdog expired tests=%0d fails=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
